if_fetch_unit: RTL and testbench

- Instruction-fetch stage placed directly in front of the combinational instruction ROM. It owns the program counter and drives the ROM byte address.
- Captures the returned 32-bit word into a small in-order queue and presents {pc, instruction} to decode over a valid/ready handshake.
- Accepts redirects (branch/jump targets) from execute and a halt request from the debug/control logic.

---
 rtl/fetch_pkg.sv | 20 ++
 rtl/fetch_queue.sv | 54 +++++
 rtl/if_fetch_unit.sv | 133 +++++++++++++
 tb/tb_if_fetch_unit.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch stage
package fetch_pkg;

    localparam int INST_W = 32;
    localparam int ADDR_W = 32;
    localparam logic [ADDR_W-1:0] PC_STEP = 32'd4;
    localparam logic [INST_W-1:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {BOOT, RUN, HALT, FAULT} fetch_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
        return addr & ~ADDR_W'(3);
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - in-order FIFO of fetched {pc, inst} entries with flush
module fetch_queue #(
    parameter int DEPTH = 2,
    parameter int W     = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  logic [W-1:0] wdata,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    // Storage is cleared on reset so the head reads zero until the first push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - PC owner and fetch queue in front of a combinational ROM
// FETCH_MISALIGN_CHK_EN adds fetch_fault and the FAULT state for misaligned redirects.
module if_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          QDEPTH      = 2,
    parameter int          BOOT_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt_req,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
`ifdef FETCH_MISALIGN_CHK_EN
    output logic        fetch_fault,
`endif
    output logic        fetch_busy
);

    fetch_state_e      state;
    logic [3:0]        boot_cnt;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] redirect_tgt;
    logic              push;
    logic              pop;
    logic              full;
    logic              empty;
    fetch_entry_t      push_entry;
    fetch_entry_t      head;

`ifdef FETCH_MISALIGN_CHK_EN
    logic misaligned;
    assign misaligned   = (redirect_pc[1:0] != 2'b00);
    assign redirect_tgt = redirect_pc;
`else
    assign redirect_tgt = word_align(redirect_pc);
`endif

    assign rom_addr   = pc_q;
    assign inst_valid = !empty;
    assign inst_pc    = head.pc;
    assign inst_data  = head.inst;
    assign pop        = inst_valid && inst_ready;
    // A halt sampled this edge already suppresses the fetch, as does any redirect.
    assign push       = (state == RUN) && !halt_req && !redirect_valid && (!full || pop);
    assign push_entry = '{pc: pc_q, inst: rom_data};

    fetch_queue #(
        .DEPTH (QDEPTH),
        .W     ($bits(fetch_entry_t))
    ) u_queue (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .wdata (push_entry),
        .full  (full),
        .empty (empty),
        .head  (head)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= BOOT;
            boot_cnt   <= '0;
            pc_q       <= RESET_PC;
            fetch_busy <= 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
            fetch_fault <= 1'b0;
`endif
        end else begin
            if (redirect_valid) begin
                pc_q <= redirect_tgt;
            end else if (push) begin
                pc_q <= pc_q + PC_STEP;
            end

            case (state)
                BOOT: begin
                    if (boot_cnt == 4'(BOOT_CYCLES)) begin
                        state      <= RUN;
                        fetch_busy <= 1'b1;
                    end else begin
                        boot_cnt <= boot_cnt + 4'd1;
                    end
                end
                RUN: begin
                    if (halt_req) begin
                        state      <= HALT;
                        fetch_busy <= 1'b0;
                    end
                end
                HALT: begin
                    if (!halt_req) begin
                        state      <= RUN;
                        fetch_busy <= 1'b1;
                    end
                end
`ifdef FETCH_MISALIGN_CHK_EN
                FAULT: begin
                    if (redirect_valid) begin
                        state       <= halt_req ? HALT : RUN;
                        fetch_busy  <= !halt_req;
                        fetch_fault <= 1'b0;
                    end
                end
`endif
                default: begin
                    state      <= BOOT;
                    fetch_busy <= 1'b0;
                end
            endcase

`ifdef FETCH_MISALIGN_CHK_EN
            // A misaligned target wins over every other transition.
            if (redirect_valid && misaligned) begin
                state       <= FAULT;
                fetch_busy  <= 1'b0;
                fetch_fault <= 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - directed and random checks of if_fetch_unit against a queue model
module tb_if_fetch_unit;

    localparam logic [31:0] RESET_PC    = 32'h0000_0000;
    localparam int          QDEPTH      = 2;
    localparam int          BOOT_CYCLES = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] rom_addr;
    logic [31:0] rom_data;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        halt_req = 1'b0;
    logic        inst_valid;
    logic        inst_ready = 1'b1;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        fetch_busy;
`ifdef FETCH_MISALIGN_CHK_EN
    logic        fetch_fault;
`endif

    int vectors = 0;
    int miscompares = 0;

    // Reference model: a queue of fetched PCs plus a few mode flags.
    logic [31:0] m_pc;
    logic [31:0] m_q[$];
    int          m_boot;
    bit          m_booted;
    bit          m_halted;
    bit          m_faulted;

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        if (a == 32'h0)  return 32'h0320_0093;
        if (a == 32'h14) return 32'hFE11_4CE3;
        return (a * 32'h9E37_79B1) ^ 32'h00C0_FFEE;
    endfunction

    assign rom_data = rom_word(rom_addr);

    if_fetch_unit #(
        .RESET_PC    (RESET_PC),
        .QDEPTH      (QDEPTH),
        .BOOT_CYCLES (BOOT_CYCLES)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .rom_addr       (rom_addr),
        .rom_data       (rom_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt_req       (halt_req),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
`ifdef FETCH_MISALIGN_CHK_EN
        .fetch_fault    (fetch_fault),
`endif
        .fetch_busy     (fetch_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = RESET_PC;
        m_q.delete();
        m_boot = 0;
        m_booted = 1'b0;
        m_halted = 1'b0;
        m_faulted = 1'b0;
    endtask

    task automatic model_edge();
        bit fetching;
        bit do_pop;
        bit do_push;
        fetching = m_booted && !m_halted && !m_faulted;
        do_pop   = (m_q.size() > 0) && inst_ready;
        do_push  = fetching && !halt_req && !redirect_valid && ((m_q.size() < QDEPTH) || do_pop);
        if (redirect_valid) begin
            m_q.delete();
`ifdef FETCH_MISALIGN_CHK_EN
            m_pc = redirect_pc;
`else
            m_pc = {redirect_pc[31:2], 2'b00};
`endif
        end else begin
            if (do_pop) void'(m_q.pop_front());
            if (do_push) begin
                m_q.push_back(m_pc);
                m_pc = m_pc + 32'd4;
            end
        end
        if (!m_booted) begin
            if (m_boot == BOOT_CYCLES) m_booted = 1'b1;
            else m_boot++;
        end else if (m_faulted) begin
            if (redirect_valid) begin
                m_faulted = 1'b0;
                m_halted = halt_req;
            end
        end else begin
            m_halted = halt_req;
        end
`ifdef FETCH_MISALIGN_CHK_EN
        if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
            m_faulted = 1'b1;
            m_booted = 1'b1;
        end
`endif
    endtask

    task automatic compare(input string ph);
        chk({ph, ".rom_addr"}, rom_addr, m_pc);
        chk({ph, ".busy"}, {31'b0, fetch_busy}, {31'b0, m_booted && !m_halted && !m_faulted});
        chk({ph, ".valid"}, {31'b0, inst_valid}, {31'b0, m_q.size() > 0});
        if (m_q.size() > 0) begin
            chk({ph, ".inst_pc"}, inst_pc, m_q[0]);
            chk({ph, ".inst_data"}, inst_data, rom_word(m_q[0]));
        end
`ifdef FETCH_MISALIGN_CHK_EN
        chk({ph, ".fault"}, {31'b0, fetch_fault}, {31'b0, m_faulted});
`endif
    endtask

    task automatic step(input string ph);
        model_edge();
        @(posedge clk);
        #1;
        compare(ph);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst.valid", {31'b0, inst_valid}, 32'd0);
        chk("rst.busy", {31'b0, fetch_busy}, 32'd0);
        chk("rst.inst_pc", inst_pc, 32'd0);
        chk("rst.inst_data", inst_data, 32'd0);
        chk("rst.rom_addr", rom_addr, RESET_PC);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        // Boot then stream with decode always ready.
        inst_ready = 1'b1;
        do_reset();
        for (int i = 0; i < 5; i++) step("boot");
        chk("boot.no_fetch_yet", {31'b0, inst_valid}, 32'd0);
        step("first");
        chk("first.valid", {31'b0, inst_valid}, 32'd1);
        chk("first.pc", inst_pc, 32'h0);
        chk("first.data", inst_data, 32'h0320_0093);
        for (int i = 0; i < 5; i++) step("stream");
        chk("stream.pc14", inst_pc, 32'h14);
        chk("stream.data14", inst_data, 32'hFE11_4CE3);

        // Backpressure from the very first fetch.
        inst_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 10; i++) step("bp");
        chk("bp.pc_stall", rom_addr, 32'h8);
        chk("bp.head", inst_pc, 32'h0);
        inst_ready = 1'b1;
        for (int i = 0; i < 3; i++) step("bp_release");
        inst_ready = 1'b0;
        for (int i = 0; i < 3; i++) step("refill");

        // Redirect on a full queue with a coincident pop.
        inst_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h4;
        step("redir");
        redirect_valid = 1'b0;
        chk("redir.flushed", {31'b0, inst_valid}, 32'd0);
        step("redir_a");
        chk("redir.next4", inst_pc, 32'h4);
        step("redir_b");
        chk("redir.next8", inst_pc, 32'h8);

        // Halt while decode drains the queue.
        halt_req = 1'b1;
        for (int i = 0; i < 3; i++) step("halt");
        chk("halt.busy", {31'b0, fetch_busy}, 32'd0);
        halt_req = 1'b0;
        for (int i = 0; i < 4; i++) step("resume");

        // Misaligned redirect.
        redirect_valid = 1'b1;
        redirect_pc = 32'h6;
        step("misalign");
        redirect_valid = 1'b0;
        for (int i = 0; i < 4; i++) step("post_misalign");
        redirect_valid = 1'b1;
        redirect_pc = 32'h8;
        step("realign");
        redirect_valid = 1'b0;
        for (int i = 0; i < 3; i++) step("post_realign");

        // PC wrap past the top of the address space.
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFF8;
        step("wrap_redir");
        redirect_valid = 1'b0;
        for (int i = 0; i < 5; i++) step("wrap");

        // Asynchronous reset in the middle of a cycle.
        rst_n = 1'b0;
        #1;
        chk("async_rst.valid", {31'b0, inst_valid}, 32'd0);
        chk("async_rst.busy", {31'b0, fetch_busy}, 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            inst_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) halt_req = ~halt_req;
            redirect_valid = ($urandom_range(0, 15) == 0);
            case ($urandom_range(0, 5))
                0:       redirect_pc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
                1:       redirect_pc = 32'($urandom_range(0, 255));
                default: redirect_pc = 32'($urandom_range(0, 63)) << 2;
            endcase
            step("rand");
        end
        redirect_valid = 1'b0;
        halt_req = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
